// File: rtl/acc_share_sched_if.sv
// Bundle between requesters/datapath and the shared-accumulator scheduler.
// slave: scheduler side; master: requesters plus accumulator datapath.
interface acc_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*CNT_W-1:0]  len_in;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      acc_clr;
  logic                      acc_en;
  logic [DATA_W-1:0]         acc_din;
  logic [DATA_W-1:0]         acc_q;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         result;

  modport slave (
    input  req, len_in, data_in, acc_q,
    output gnt, busy, acc_clr, acc_en,
    output acc_din, done, result
  );

  modport master (
    output req, len_in, data_in, acc_q,
    input  gnt, busy, acc_clr, acc_en,
    input  acc_din, done, result
  );
endinterface

// File: rtl/acc_share_sched.sv
// Round-robin scheduler sharing one accumulator among NUM_REQ requesters.
// Ports: clk, rst_n (async low), bus (slave): req/len/data in, grant/done/result out.
module acc_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
) (
  input logic         clk,
  input logic         rst_n,
  acc_share_sched_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      win_q, win_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [IW-1:0]      pick;
  logic               found;
  logic               en;

  // First set request at or above ptr, wrapping past NUM_REQ-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_REQ'(1) << pick;
          win_d   = pick;
          cnt_d   = bus.len_in[pick*CNT_W +: CNT_W];
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (cnt_q == '0) ? DONE : RUN;
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        res_d   = bus.acc_q;
        gnt_d   = '0;
        // Rotate so the other requesters get first look next time.
        if (win_q == IW'(NUM_REQ - 1)) ptr_d = '0;
        else ptr_d = win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign en          = (state_q == RUN);
  assign bus.acc_en  = en;
  assign bus.acc_clr = (state_q == CLEAR);
  assign bus.busy    = (state_q != IDLE);
  assign bus.acc_din = en ? bus.data_in[win_q*DATA_W +: DATA_W]
                          : '0;
  assign bus.done    = (state_q == DONE) ? gnt_q : '0;
  assign bus.gnt     = gnt_q;
  assign bus.result  = res_q;
endmodule
